cpu_debug_panel: RTL and testbench

- Board-level companion stage to the multi-cycle CPU top.
- Upstream role: debounces the single-step push-button and emits a one-cycle `cpu_step` enable that advances the CPU one clock.
- Downstream role: consumes CPU observation buses (PC, next PC, register addresses/data, ALU result, DB bus) and time-multiplexes a selected pair of bytes onto a 4-digit seven-segment display via `pos_ctrl`/`num_ctrl`.

---
 rtl/cpu_debug_panel_pkg.sv | 33 +++
 rtl/cpu_debug_panel_step_debouncer.sv | 78 +++++++
 rtl/cpu_debug_panel.sv | 109 ++++++++++
 tb/tb_cpu_debug_panel.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_debug_panel_pkg.sv
// Shared definitions for the CPU debug panel.
// Contents:
//   mode_e       - display-select encodings for the 2-bit mode input
//   deb_state_e  - step-button debounce FSM states
//   HEX_SEG      - hex digit to active-low segment pattern {dp,g,f,e,d,c,b,a}, dp off
//   SEG_OFF      - all segments dark
//   DIG_OFF      - all digit enables inactive
package cpu_debug_panel_pkg;

  typedef enum logic [1:0] {
    MODE_PC  = 2'b00,
    MODE_RS  = 2'b01,
    MODE_RT  = 2'b10,
    MODE_ALU = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } deb_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] DIG_OFF = 4'b1111;

  // Element n holds the pattern for hex digit n (listed F down to 0).
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/cpu_debug_panel_step_debouncer.sv
// Step-button conditioner: two-flop synchroniser, debounce FSM and stability counter.
// Emits a single-cycle cpu_step for each accepted press, however long it is held.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   btn      - raw, asynchronous, bouncy button (high = pressed)
//   cpu_step - registered one-cycle step pulse
module step_debouncer
  import cpu_debug_panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic cpu_step
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            btn_s;
  deb_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            step_q;

  assign btn_s    = sync_q[1];
  assign cpu_step = step_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      state_q <= StIdle;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      step_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (btn_s) begin
            state_q <= StPressWait;
            cnt_q   <= '0;
          end
        end
        StPressWait: begin
          if (!btn_s) begin
            state_q <= StIdle;
          end else if (cnt_q == CntLast) begin
            state_q <= StPressed;
            step_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StPressed: begin
          if (!btn_s) begin
            state_q <= StReleaseWait;
            cnt_q   <= '0;
          end
        end
        StReleaseWait: begin
          // A bounce back high returns to PRESSED silently: still the same press.
          if (btn_s) begin
            state_q <= StPressed;
          end else if (cnt_q == CntLast) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/cpu_debug_panel.sv
// Board-level debug panel for the multi-cycle CPU.
// Debounces the single-step button into a one-cycle cpu_step and scans a selected
// 16-bit view of the CPU state across a 4-digit active-low seven-segment display.
// Ports:
//   clk, RST             - clock and synchronous active-high reset
//   btn_step             - raw step button
//   mode                 - display select (see mode_e)
//   pc .. db_data        - CPU observation buses (low byte of each is displayed)
//   cpu_step             - one-cycle step enable to the CPU
//   pos_ctrl             - digit enables, active-low, bit3 = leftmost
//   num_ctrl             - segments, active-low, {dp,g,f,e,d,c,b,a}
module cpu_debug_panel
  import cpu_debug_panel_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        btn_step,
  input  logic [1:0]  mode,
  input  logic [31:0] pc,
  input  logic [31:0] newpc,
  input  logic [4:0]  rs_addr,
  input  logic [31:0] rs_data,
  input  logic [4:0]  rt_addr,
  input  logic [31:0] rt_data,
  input  logic [31:0] alu_result,
  input  logic [31:0] db_data,
  output logic        cpu_step,
  output logic [3:0]  pos_ctrl,
  output logic [7:0]  num_ctrl
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);

  step_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .clk     (clk),
    .rst     (RST),
    .btn     (btn_step),
    .cpu_step(cpu_step)
  );

  // Only the low byte of each wide bus is displayed.
  logic unused_hi;
  assign unused_hi = ^{pc[31:8], newpc[31:8], rs_data[31:8], rt_data[31:8],
                       alu_result[31:8], db_data[31:8]};

  logic [ScanW-1:0] scan_q;
  logic [1:0]       digit_q;
  logic [15:0]      snap_q;
  logic [3:0]       pos_q;
  logic [7:0]       num_q;

  logic [15:0] mux_val;
  logic [1:0]  digit_next;
  logic [15:0] snap_next;
  logic [3:0]  nib_next;
  logic [7:0]  seg_next;

  always_comb begin
    mux_val = '0;
    case (mode_e'(mode))
      MODE_PC:  mux_val = {pc[7:0], newpc[7:0]};
      MODE_RS:  mux_val = {3'b000, rs_addr, rs_data[7:0]};
      MODE_RT:  mux_val = {3'b000, rt_addr, rt_data[7:0]};
      MODE_ALU: mux_val = {alu_result[7:0], db_data[7:0]};
      default:  mux_val = '0;
    endcase
  end

  // Snapshot is taken on entry to digit 0 and used by that same digit, so a whole
  // frame shows one coherent value even if mode or the buses change mid-frame.
  always_comb begin
    digit_next = digit_q + 2'd1;
    snap_next  = (digit_next == 2'd0) ? mux_val : snap_q;
    nib_next   = snap_next[{digit_next, 2'b00} +: 4];
    seg_next   = HEX_SEG[nib_next];
    // Decimal point on the third digit splits left byte from right byte.
    if (digit_next == 2'd2) begin
      seg_next[7] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      scan_q  <= '0;
      digit_q <= 2'd3;
      snap_q  <= 16'h0000;
      pos_q   <= DIG_OFF;
      num_q   <= SEG_OFF;
    end else if (scan_q == ScanLast) begin
      scan_q  <= '0;
      digit_q <= digit_next;
      snap_q  <= snap_next;
      pos_q   <= ~(4'b0001 << digit_next);
      num_q   <= seg_next;
    end else begin
      scan_q <= scan_q + ScanW'(1);
    end
  end

  assign pos_ctrl = pos_q;
  assign num_ctrl = num_q;

endmodule

// File: tb/tb_cpu_debug_panel.sv
// Self-checking bench for cpu_debug_panel with SCAN_DIV=3, DEBOUNCE_CYCLES=4.
module tb_cpu_debug_panel;

  localparam int SCAN = 3;
  localparam int DEB  = 4;

  logic        clk;
  logic        RST;
  logic        btn_step;
  logic [1:0]  mode;
  logic [31:0] pc, newpc, rs_data, rt_data, alu_result, db_data;
  logic [4:0]  rs_addr, rt_addr;
  logic        cpu_step;
  logic [3:0]  pos_ctrl;
  logic [7:0]  num_ctrl;

  cpu_debug_panel #(
    .SCAN_DIV       (SCAN),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .btn_step  (btn_step),
    .mode      (mode),
    .pc        (pc),
    .newpc     (newpc),
    .rs_addr   (rs_addr),
    .rs_data   (rs_data),
    .rt_addr   (rt_addr),
    .rt_data   (rt_data),
    .alu_result(alu_result),
    .db_data   (db_data),
    .cpu_step  (cpu_step),
    .pos_ctrl  (pos_ctrl),
    .num_ctrl  (num_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;
  int tick_no = 0;
  int pulses = 0;
  int first_pulse = -1;

  // Reference model state
  logic [1:0]  m_hist;   // btn_step samples from the last two edges
  logic        m_level;  // currently accepted button level
  int          m_run;    // consecutive synchronised samples disagreeing with m_level
  logic        m_step;
  int          m_n;      // edges since reset release
  logic [15:0] m_snap;
  logic [3:0]  m_pos;
  logic [7:0]  m_num;
  logic        m_adv0;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [15:0] sel_value();
    case (mode)
      2'd0:    return {pc[7:0], newpc[7:0]};
      2'd1:    return {3'b000, rs_addr, rs_data[7:0]};
      2'd2:    return {3'b000, rt_addr, rt_data[7:0]};
      default: return {alu_result[7:0], db_data[7:0]};
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs the DUT is about to sample.
  task automatic model_step();
    logic bs;
    int d;
    m_adv0 = 1'b0;
    if (RST) begin
      m_hist = 2'b00; m_level = 1'b0; m_run = 0; m_step = 1'b0;
      m_n = 0; m_snap = 16'h0000; m_pos = 4'hF; m_num = 8'hFF;
    end else begin
      bs     = m_hist[1];
      m_hist = {m_hist[0], btn_step};
      m_step = 1'b0;
      // A new level is accepted after DEB+1 consecutive disagreeing samples.
      if (bs == m_level) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_level = bs;
          m_run   = 0;
          m_step  = bs;
        end
      end
      m_n++;
      if (m_n % SCAN == 0) begin
        d = ((m_n / SCAN) - 1) % 4;
        if (d == 0) begin
          m_snap = sel_value();
          m_adv0 = 1'b1;
        end
        m_pos = ~(4'b0001 << d);
        m_num = hex_seg(m_snap[d*4 +: 4]);
        if (d == 2) m_num[7] = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s at tick %0d: got %h, expected %h", name, tick_no, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    tick_no++;
    check("cpu_step", {31'd0, cpu_step}, {31'd0, m_step});
    check("pos_ctrl", {28'd0, pos_ctrl}, {28'd0, m_pos});
    check("num_ctrl", {24'd0, num_ctrl}, {24'd0, m_num});
    if (cpu_step === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = tick_no;
    end
  endtask

  task automatic wait_digit0();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!m_adv0 && k < 4 * SCAN + 2);
    if (!m_adv0) begin
      miss++;
      $display("FAIL wait_digit0: no digit-0 advance within %0d ticks", k);
    end
  endtask

  task automatic press_and_check(input string name, input int hold, input int exp_pulses,
                                 input int exp_lat);
    int t0, p0;
    btn_step = 1'b1; t0 = tick_no; p0 = pulses; first_pulse = -1;
    repeat (hold) tick();
    check({name, "_count"}, pulses - p0, exp_pulses);
    if (exp_lat >= 0) check({name, "_latency"}, first_pulse - t0, exp_lat);
  endtask

  typedef struct {
    logic [1:0]       mode;
    logic [4:0]       addr;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [3:0][7:0]  num;  // expected num_ctrl, index = digit
  } disp_vec_t;

  disp_vec_t  tbl[6];
  logic [3:0] pos_tab[4];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int hold;
    tbl[0] = '{2'd0, 5'd0,  32'h0000_0014, 32'h0000_0018, {8'hF9, 8'h19, 8'hF9, 8'h80}};
    tbl[1] = '{2'd3, 5'd0,  32'h1234_56AB, 32'hFFFF_FF0C, {8'h88, 8'h03, 8'hC0, 8'hC6}};
    tbl[2] = '{2'd1, 5'd31, 32'h0,         32'h0000_00FF, {8'hF9, 8'h0E, 8'h8E, 8'h8E}};
    tbl[3] = '{2'd2, 5'd10, 32'h0,         32'hCAFE_005D, {8'hC0, 8'h08, 8'h92, 8'hA1}};
    tbl[4] = '{2'd0, 5'd0,  32'hFFFF_FF7E, 32'h0000_0096, {8'hF8, 8'h06, 8'h90, 8'h82}};
    tbl[5] = '{2'd1, 5'd3,  32'h0,         32'h1111_1127, {8'hC0, 8'h30, 8'hA4, 8'hF8}};
    pos_tab[0] = 4'b1110; pos_tab[1] = 4'b1101; pos_tab[2] = 4'b1011; pos_tab[3] = 4'b0111;

    RST = 1'b1; btn_step = 1'b0; mode = 2'd0;
    pc = 0; newpc = 0; rs_addr = 0; rs_data = 0; rt_addr = 0; rt_data = 0;
    alu_result = 0; db_data = 0;
    tick(); tick();
    check("reset_pos", {28'd0, pos_ctrl}, 32'hF);
    check("reset_num", {24'd0, num_ctrl}, 32'hFF);
    check("reset_step", {31'd0, cpu_step}, 32'd0);
    RST = 1'b0;

    // Held press: one pulse at edge DEB+3, none while held; release; second press.
    press_and_check("press1", 30, 1, DEB + 3);
    btn_step = 1'b0; p0 = pulses;
    repeat (12) tick();
    check("release_nopulse", pulses - p0, 0);
    press_and_check("press2", 20, 1, DEB + 3);
    btn_step = 1'b0;
    repeat (12) tick();

    // Glitch shorter than the debounce window.
    press_and_check("glitch", 3, 0, -1);
    btn_step = 1'b0; p0 = pulses;
    repeat (15) tick();
    check("glitch_nopulse", pulses - p0, 0);

    // Bounce during release must not yield a second pulse.
    press_and_check("bounce_press", 10, 1, DEB + 3);
    p0 = pulses;
    btn_step = 1'b0; repeat (2) tick();
    btn_step = 1'b1; repeat (2) tick();
    btn_step = 1'b0; repeat (15) tick();
    check("bounce_nopulse", pulses - p0, 0);

    // Table-driven display frames; unselected buses carry random data.
    for (int i = 0; i < 6; i++) begin
      pc = $urandom; newpc = $urandom; rs_addr = 5'($urandom); rs_data = $urandom;
      rt_addr = 5'($urandom); rt_data = $urandom; alu_result = $urandom; db_data = $urandom;
      mode = tbl[i].mode;
      case (tbl[i].mode)
        2'd0: begin pc = tbl[i].a; newpc = tbl[i].b; end
        2'd1: begin rs_addr = tbl[i].addr; rs_data = tbl[i].b; end
        2'd2: begin rt_addr = tbl[i].addr; rt_data = tbl[i].b; end
        default: begin alu_result = tbl[i].a; db_data = tbl[i].b; end
      endcase
      wait_digit0();
      for (int d = 0; d < 4; d++) begin
        if (d > 0) repeat (SCAN) tick();
        check($sformatf("tbl%0d_num_d%0d", i, d), {24'd0, num_ctrl}, {24'd0, tbl[i].num[d]});
        check($sformatf("tbl%0d_pos_d%0d", i, d), {28'd0, pos_ctrl}, {28'd0, pos_tab[d]});
      end
    end

    // Mode change mid-frame takes effect at the next digit-0 advance.
    mode = 2'd3; alu_result = 32'h0000_00AB; db_data = 32'h0000_000C;
    wait_digit0();
    check("midframe_d0", {24'd0, num_ctrl}, 32'hC6);
    repeat (SCAN) tick();
    check("midframe_d1", {24'd0, num_ctrl}, 32'hC0);
    mode = 2'd1; rs_addr = 5'd31; rs_data = 32'h0000_00FF;
    repeat (SCAN) tick();
    check("midframe_d2", {24'd0, num_ctrl}, 32'h03);
    repeat (SCAN) tick();
    check("midframe_d3", {24'd0, num_ctrl}, 32'h88);
    repeat (SCAN) tick();
    check("newframe_d0", {24'd0, num_ctrl}, 32'h8E);
    check("newframe_pos", {28'd0, pos_ctrl}, 32'hE);
    repeat (3 * SCAN) tick();
    check("newframe_d3", {24'd0, num_ctrl}, 32'hF9);

    // Reset mid-press and mid-scan.
    btn_step = 1'b1;
    repeat (4) tick();
    repeat (1) tick();
    RST = 1'b1; btn_step = 1'b0;
    tick();
    check("rst_pos", {28'd0, pos_ctrl}, 32'hF);
    check("rst_num", {24'd0, num_ctrl}, 32'hFF);
    check("rst_step", {31'd0, cpu_step}, 32'd0);
    RST = 1'b0; p0 = pulses;
    for (int i = 1; i < SCAN; i++) begin
      tick();
      check("rst_hold_pos", {28'd0, pos_ctrl}, 32'hF);
    end
    tick();
    check("rst_first_digit", {28'd0, pos_ctrl}, 32'hE);
    repeat (15) tick();
    check("rst_nopulse", pulses - p0, 0);

    // Randomised run against the model.
    hold = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold == 0) begin
        btn_step = 1'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        pc = $urandom; newpc = $urandom; rs_addr = 5'($urandom); rs_data = $urandom;
        rt_addr = 5'($urandom); rt_data = $urandom; alu_result = $urandom; db_data = $urandom;
      end
      RST = ($urandom_range(0, 299) == 0);
      tick();
    end
    RST = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
